// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master/target pair: CPU register addresses,
// status bit positions, SPI mode-0 constants and the target FSM state type.
// No ports (package).
// ---------------------------------------------------------------------------
package spi_pkg;

    // CPU register map (1-bit address)
    localparam logic ADDR_CTL  = 1'b0;   // status / control
    localparam logic ADDR_DATA = 1'b1;   // rx / tx data

    // Status register (addr0) bit positions
    localparam int ST_ACTIVE  = 7;
    localparam int ST_RXVALID = 6;
    localparam int ST_OVERRUN = 5;
    localparam int ST_TXEMPTY = 4;
    localparam int ST_IEN_TX  = 2;
    localparam int ST_IEN_RX  = 1;
    localparam int ST_SS      = 0;

    // Control write (addr0) bit positions
    localparam int CTL_OVR_CLR = 5;

    // SPI mode 0: clock idles low, data sampled on the rising edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;
    localparam int   SPI_BITS = 8;

    typedef enum logic {
        SLV_IDLE   = 1'b0,
        SLV_ACTIVE = 1'b1
    } slv_state_t;

endpackage

// File: rtl/spi_sync.sv
// ---------------------------------------------------------------------------
// spi_sync
// N-stage flip-flop synchronizer for one asynchronous SPI pin.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset (chain loads RESET_VAL)
//   i_d      asynchronous input
//   o_q      synchronized output (SYNC_STAGES cycles of latency)
// ---------------------------------------------------------------------------
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI mode-0 target. SCK/SS/MOSI are oversampled through synchronizers on
// i_clk; received bytes are posted to a CPU-readable data register and the
// TX holding register is shifted out on MISO, one byte per 8 SCK periods.
// Optional feature macro: SPI_SLAVE_IRQ_MASK_EN (addr0 bits 1/2 become
// rx-done / tx-empty interrupt enables).
// Ports:
//   i_clk, i_reset        system clock, synchronous active-high reset
//   i_addr, i_cs, i_we    CPU register access (0 = status/ctl, 1 = data)
//   i_dat / o_dat         CPU write data / combinational read data
//   i_sck, i_ss, i_mosi   SPI pins from the master (asynchronous)
//   o_miso, o_miso_oe     SPI data out and its pad output enable
//   o_irq                 one-cycle interrupt pulse
// ---------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter logic       SS_ACTIVE   = 1'b1,
    parameter logic [7:0] TX_IDLE     = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_addr,
    input  logic       i_cs,
    input  logic       i_we,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic       i_sck,
    input  logic       i_ss,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_miso_oe,
    output logic       o_irq
);

    logic       w_sck_s, w_ss_s, w_mosi_s;
    logic       r_sck_d;
    slv_state_t r_state;
    logic [2:0] r_bitcnt;
    logic [6:0] r_rx_shift;      // only 7 bits kept; the 8th arrives with the post
    logic [7:0] r_tx_shift;
    logic [7:0] r_rx_data;
    logic [7:0] r_tx_hold;
    logic       r_rx_valid, r_overrun, r_tx_empty, r_irq;
`ifdef SPI_SLAVE_IRQ_MASK_EN
    logic       r_ien_rx, r_ien_tx;
`endif

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_sck), .o_q(w_sck_s));
    // Reset the select chain to the inactive level so reset never looks like a select
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(~SS_ACTIVE)) u_sync_ss (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_ss), .o_q(w_ss_s));
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_mosi), .o_q(w_mosi_s));

    logic       w_sel, w_sck_rise, w_sck_fall, w_select, w_run;
    logic       w_rx_post, w_tx_load, w_irq_next;
    logic       w_cpu_rd_data, w_cpu_wr_data, w_cpu_wr_ctl;
    logic [7:0] w_tx_next;

    assign w_sel      = (w_ss_s == SS_ACTIVE);
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;
    assign w_select   = (r_state == SLV_IDLE) & w_sel;
    assign w_run      = (r_state == SLV_ACTIVE) & w_sel;
    assign w_rx_post  = w_run & w_sck_rise & (r_bitcnt == 3'd7);
    // Byte boundary: the falling edge after the 8th rise (bitcnt has wrapped to 0)
    assign w_tx_load  = w_select | (w_run & w_sck_fall & (r_bitcnt == 3'd0));
    assign w_tx_next  = r_tx_empty ? TX_IDLE : r_tx_hold;

    assign w_cpu_rd_data = i_cs & ~i_we & (i_addr == ADDR_DATA);
    assign w_cpu_wr_data = i_cs &  i_we & (i_addr == ADDR_DATA);
    assign w_cpu_wr_ctl  = i_cs &  i_we & (i_addr == ADDR_CTL);

`ifdef SPI_SLAVE_IRQ_MASK_EN
    assign w_irq_next = (w_rx_post & r_ien_rx) | (w_tx_load & r_ien_tx);
`else
    assign w_irq_next = w_rx_post;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= SLV_IDLE;
            r_sck_d    <= 1'b0;
            r_bitcnt   <= 3'd0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_rx_data  <= '0;
            r_tx_hold  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_tx_empty <= 1'b1;
            r_irq      <= 1'b0;
`ifdef SPI_SLAVE_IRQ_MASK_EN
            r_ien_rx   <= 1'b0;
            r_ien_tx   <= 1'b0;
`endif
        end else begin
            r_sck_d <= w_sck_s;
            r_irq   <= w_irq_next;

            // CPU-side clears come first so same-cycle SPI events override them
            if (w_cpu_rd_data)
                r_rx_valid <= 1'b0;
            if (w_cpu_wr_ctl && i_dat[CTL_OVR_CLR])
                r_overrun <= 1'b0;
`ifdef SPI_SLAVE_IRQ_MASK_EN
            if (w_cpu_wr_ctl) begin
                r_ien_rx <= i_dat[ST_IEN_RX];
                r_ien_tx <= i_dat[ST_IEN_TX];
            end
`endif

            case (r_state)
                SLV_IDLE: begin
                    if (w_sel) begin
                        r_state  <= SLV_ACTIVE;
                        r_bitcnt <= 3'd0;
                    end
                end
                SLV_ACTIVE: begin
                    if (!w_sel) begin
                        // Deselect drops any partial byte
                        r_state    <= SLV_IDLE;
                        r_bitcnt   <= 3'd0;
                        r_rx_shift <= '0;
                        r_tx_shift <= '0;
                    end else begin
                        if (w_sck_rise) begin
                            r_rx_shift <= {r_rx_shift[5:0], w_mosi_s};
                            r_bitcnt   <= r_bitcnt + 3'd1;
                        end
                        if (w_sck_fall && r_bitcnt != 3'd0)
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end
                end
                default: r_state <= SLV_IDLE;
            endcase

            if (w_tx_load) begin
                r_tx_shift <= w_tx_next;
                r_tx_empty <= 1'b1;
            end

            if (w_rx_post) begin
                r_rx_data  <= {r_rx_shift, w_mosi_s};
                r_rx_valid <= 1'b1;
                // A byte read in this very cycle is not lost, so no overrun
                if (r_rx_valid && !w_cpu_rd_data)
                    r_overrun <= 1'b1;
            end

            // A CPU write lands after any reload, so the shifter keeps the old value
            if (w_cpu_wr_data) begin
                r_tx_hold  <= i_dat;
                r_tx_empty <= 1'b0;
            end
        end
    end

    always_comb begin
        o_dat = r_rx_data;
        if (i_addr == ADDR_CTL) begin
            o_dat             = '0;
            o_dat[ST_ACTIVE]  = (r_state == SLV_ACTIVE);
            o_dat[ST_RXVALID] = r_rx_valid;
            o_dat[ST_OVERRUN] = r_overrun;
            o_dat[ST_TXEMPTY] = r_tx_empty;
`ifdef SPI_SLAVE_IRQ_MASK_EN
            o_dat[ST_IEN_RX]  = r_ien_rx;
            o_dat[ST_IEN_TX]  = r_ien_tx;
`endif
            o_dat[ST_SS]      = w_ss_s;
        end
    end

    assign o_miso_oe = (r_state == SLV_ACTIVE);
    assign o_miso    = (r_state == SLV_ACTIVE) & r_tx_shift[7];
    assign o_irq     = r_irq;

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
// Drives spi_slave as a mode-0 SPI master plus a CPU, and compares against a
// byte-level model of the target (TX holding register, RX data, flags, irq
// count).
// ---------------------------------------------------------------------------
module tb_spi_slave;

    localparam int H = 6;   // SCK half period in i_clk cycles

    logic       clk = 1'b0;
    logic       i_reset, i_addr, i_cs, i_we;
    logic [7:0] i_dat, o_dat;
    logic       i_sck, i_ss, i_mosi;
    logic       o_miso, o_miso_oe, o_irq;

    always #5 clk = ~clk;

    spi_slave dut (
        .i_clk(clk), .i_reset(i_reset), .i_addr(i_addr), .i_cs(i_cs),
        .i_we(i_we), .i_dat(i_dat), .o_dat(o_dat), .i_sck(i_sck),
        .i_ss(i_ss), .i_mosi(i_mosi), .o_miso(o_miso),
        .o_miso_oe(o_miso_oe), .o_irq(o_irq)
    );

    int checks = 0;
    int errors = 0;
    int irq_seen = 0;

    // Byte-level model
    logic [7:0] m_hold, m_rxd;
    bit         m_empty, m_valid, m_ovr;
    int         m_irq;

    // Hooks for CPU accesses placed inside an SCK high phase
    int         hk_rd_bit = -1, hk_rd_cyc = 0;
    int         hk_wr_bit = -1, hk_wr_cyc = 0;
    logic [7:0] hk_wr_val = 8'h00, hk_rd_val = 8'h00;

    always @(negedge clk) if (o_irq === 1'b1) irq_seen++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] d);
        i_cs = 1'b1; i_we = 1'b1; i_addr = a; i_dat = d;
        @(negedge clk);
        i_cs = 1'b0; i_we = 1'b0;
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] d);
        i_cs = 1'b1; i_we = 1'b0; i_addr = a;
        #1 d = o_dat;
        @(negedge clk);
        i_cs = 1'b0;
    endtask

    task automatic m_load(output logic [7:0] v);
        v = m_empty ? 8'h00 : m_hold;
        m_empty = 1'b1;
    endtask

    task automatic m_post(input logic [7:0] b);
        if (m_valid) m_ovr = 1'b1;
        m_rxd = b; m_valid = 1'b1; m_irq++;
    endtask

    task automatic m_reset();
        m_hold = 8'h00; m_rxd = 8'h00;
        m_empty = 1'b1; m_valid = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic host_write_tx(input logic [7:0] d);
        cpu_write(1'b1, d);
        m_hold = d; m_empty = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [7:0] st;
        cpu_read(1'b0, st);
        check(tag, st, {1'b0, m_valid, m_ovr, m_empty, 4'b0000});
    endtask

    task automatic check_rxdata(input string tag);
        logic [7:0] v;
        cpu_read(1'b1, v);
        check(tag, v, m_rxd);
        m_valid = 1'b0;
    endtask

    // Shift nbits MSB-first; master samples MISO just before each rising edge
    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            i_mosi = mo[7-b];
            cyc(H);
            mi[7-b] = o_miso;
            i_sck = 1'b1;
            for (int c = 0; c < H; c++) begin
                if (b == hk_rd_bit && c == hk_rd_cyc) cpu_read(1'b1, hk_rd_val);
                else if (b == hk_wr_bit && c == hk_wr_cyc) cpu_write(1'b1, hk_wr_val);
                else @(negedge clk);
            end
            i_sck = 1'b0;
        end
    endtask

    task automatic spi_deselect();
        cyc(H);
        i_ss = 1'b0;
        cyc(H);
    endtask

    task automatic run_frame(input int nb, input logic [7:0] mo [4],
                             input bit mid_wr, input logic [7:0] mid_val);
        logic [7:0] cur, mi;
        i_ss = 1'b1;
        m_load(cur);
        for (int i = 0; i < nb; i++) begin
            if (mid_wr && i == 0) begin
                hk_wr_bit = 3; hk_wr_cyc = 2; hk_wr_val = mid_val;
            end
            spi_bits(mo[i], 8, mi);
            hk_wr_bit = -1;
            if (mid_wr && i == 0) begin m_hold = mid_val; m_empty = 1'b0; end
            check("miso_byte", mi, cur);
            m_post(mo[i]);
            m_load(cur);
        end
        spi_deselect();
        check("irq_count", irq_seen, m_irq);
        check_status("status_after_frame");
    endtask

    initial begin
        logic [7:0] cur, mi, v, st, p, q;
        logic [7:0] rb [4];
        int n_old, n_new, nb;
        bit mid;

        i_reset = 1'b1; i_addr = 1'b0; i_cs = 1'b0; i_we = 1'b0; i_dat = 8'h00;
        i_sck = 1'b0; i_ss = 1'b0; i_mosi = 1'b0;
        m_reset(); m_irq = 0;
        cyc(3);
        i_reset = 1'b0;
        cyc(2);

        // Reset state
        check("rst_miso", o_miso, 1'b0);
        check("rst_miso_oe", o_miso_oe, 1'b0);
        check("rst_irq", o_irq, 1'b0);
        check_status("rst_status");
        check_rxdata("rst_rxdata");

        // Loopback: tx A5, master sends 3C
        host_write_tx(8'hA5);
        check_status("txhold_loaded");
        run_frame(1, '{8'h3C, 8'h00, 8'h00, 8'h00}, 1'b0, 8'h00);
        check_rxdata("loop_rx");

        // Empty TX: master reads TX_IDLE
        run_frame(1, '{8'h81, 8'h00, 8'h00, 8'h00}, 1'b0, 8'h00);
        check_rxdata("empty_rx");

        // Overrun: two bytes without a CPU read, then clear
        run_frame(2, '{8'h11, 8'h22, 8'h00, 8'h00}, 1'b0, 8'h00);
        check_rxdata("overrun_rx");
        cpu_write(1'b0, 8'h20); m_ovr = 1'b0;
        check_status("overrun_cleared");

        // Deselect after 4 SCKs, then a full byte
        i_ss = 1'b1;
        m_load(cur);
        spi_bits(8'hF0, 4, mi);
        check("partial_miso", mi[7:4], cur[7:4]);
        spi_deselect();
        check("partial_no_irq", irq_seen, m_irq);
        check_status("partial_status");
        host_write_tx(8'h96);
        run_frame(1, '{8'h5A, 8'h00, 8'h00, 8'h00}, 1'b0, 8'h00);
        check_rxdata("realign_rx");

        // CPU data read swept across the RX post cycle with an unread byte pending
        n_old = 0; n_new = 0;
        for (int d = 0; d < H; d++) begin
            p = 8'h40 + 8'(d);
            q = 8'hC0 + 8'(d);
            run_frame(1, '{p, 8'h00, 8'h00, 8'h00}, 1'b0, 8'h00);
            i_ss = 1'b1;
            m_load(cur);
            hk_rd_bit = 7; hk_rd_cyc = d;
            spi_bits(q, 8, mi);
            hk_rd_bit = -1;
            m_load(cur);
            spi_deselect();
            m_irq++;
            check("sweep_irq", irq_seen, m_irq);
            cpu_read(1'b0, st);
            if (hk_rd_val === p) begin
                n_old++;
                check("same_cyc_valid", st[6], 1'b1);
                check("same_cyc_ovr", st[5], 1'b0);
            end else begin
                n_new++;
                check("late_rd_data", hk_rd_val, q);
                check("late_rd_valid", st[6], 1'b0);
                check("late_rd_ovr", st[5], 1'b1);
            end
            cpu_read(1'b1, v);
            check("sweep_rx", v, q);
            cpu_write(1'b0, 8'h20);
            m_rxd = q; m_valid = 1'b0; m_ovr = 1'b0;
        end
        check("sweep_old_seen", (n_old > 0), 1'b1);
        check("sweep_new_seen", (n_new > 0), 1'b1);

        // Randomized frames
        for (int k = 0; k < 8; k++) begin
            nb = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) rb[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) host_write_tx(8'($urandom));
            mid = ($urandom_range(0, 2) == 0);
            run_frame(nb, rb, mid, 8'($urandom));
            if ($urandom_range(0, 1) == 1) check_rxdata("rand_rx");
            if (m_ovr) begin
                cpu_write(1'b0, 8'h20); m_ovr = 1'b0;
            end
        end
        check_status("rand_status");

        // Reset asserted mid-byte
        host_write_tx(8'hC7);
        i_ss = 1'b1;
        m_load(cur);
        spi_bits(8'hAA, 4, mi);
        i_reset = 1'b1;
        @(negedge clk);
        check("midrst_miso", o_miso, 1'b0);
        check("midrst_miso_oe", o_miso_oe, 1'b0);
        check("midrst_irq", o_irq, 1'b0);
        i_addr = 1'b0;
        #1 check("midrst_status", o_dat, 8'h10);
        i_addr = 1'b1;
        #1 check("midrst_rxdata", o_dat, 8'h00);
        i_reset = 1'b0;
        i_ss = 1'b0;
        m_reset();
        cyc(2 * H);
        check_status("post_rst_status");
        host_write_tx(8'hE1);
        run_frame(1, '{8'h3E, 8'h00, 8'h00, 8'h00}, 1'b0, 8'h00);
        check_rxdata("post_rst_rx");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
